muldiv_hilo_unit: RTL and testbench

Iterative multiply/divide engine and HI/LO register file in the EX stage. It sits directly downstream of the ALU control unit and consumes its `con`, `hiloW`, `hiloR` and `hiloS` outputs. Multiply/divide operations with `hiloW` set execute here over multiple cycles, while the main ALU handles single-cycle operations. It also returns HI or LO for `mfhi`/`mflo` and raises a pipeline stall while a result is pending.

---
 rtl/alu_pkg.sv | 17 +
 rtl/muldiv_hilo_unit_if.sv | 18 +
 rtl/seq_muldiv_core.sv | 126 ++++++++++++
 rtl/muldiv_hilo_unit.sv | 42 ++++
 tb/tb_muldiv_hilo_unit.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control encodings and the multiply/divide sequencer state type.
package alu_pkg;
  localparam logic [3:0] CON_MULU = 4'b1100;
  localparam logic [3:0] CON_DIVU = 4'b1101;
  localparam logic [3:0] CON_MUL  = 4'b1110;
  localparam logic [3:0] CON_DIV  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdState_e;

  function automatic logic isMulDiv(logic [3:0] con);
    return con[3:2] == 2'b11;
  endfunction
endpackage

// File: rtl/muldiv_hilo_unit_if.sv
// EX-stage request/readback bundle between the pipeline and the HI/LO unit.
interface muldiv_hilo_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       con;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             hilo_rd;
  logic             hilo_sel;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             stall;
  logic             done;

  modport master (output start, con, op_a, op_b, hilo_rd, hilo_sel,
                  input  rd_data, busy, stall, done);
  modport slave  (input  start, con, op_a, op_b, hilo_rd, hilo_sel,
                  output rd_data, busy, stall, done);
endinterface

// File: rtl/seq_muldiv_core.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// state | meaning
// IDLE  | waiting for an accepted start
// RUN   | WIDTH iterations; counter tracks the bit index
// FIX   | signs/special cases applied; result presented with done high
module seq_muldiv_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       con,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] resHi,
  output logic [WIDTH-1:0] resLo
);
  localparam logic [5:0] LAST = 6'(WIDTH - 1);

  mdState_e         state;
  logic [5:0]       cnt;
  logic [3:0]       conQ;
  logic [WIDTH-1:0] magB;
  logic [WIDTH-1:0] origA;
  logic             resNeg;
  logic             aNeg;
  logic [WIDTH-1:0] hiAcc;
  logic [WIDTH-1:0] loAcc;

  logic             accept, sgn, aNegIn, bNegIn, isMulQ, isDivQ;
  logic [WIDTH-1:0] magAIn, magBIn;
  logic [WIDTH:0]   mulSum, divShift, divDiff;
  logic [2*WIDTH-1:0] prod;

  // A new op may also be taken in FIX so a held start chains without a bubble.
  assign accept  = start && isMulDiv(con) && (state == IDLE || state == FIX);
  assign sgn     = (con == CON_MUL) || (con == CON_DIV);
  assign aNegIn  = sgn & opA[WIDTH-1];
  assign bNegIn  = sgn & opB[WIDTH-1];
  assign magAIn  = aNegIn ? -opA : opA;
  assign magBIn  = bNegIn ? -opB : opB;
  assign isMulQ  = (conQ == CON_MULU) || (conQ == CON_MUL);
  assign isDivQ  = (conQ == CON_DIVU) || (conQ == CON_DIV);

  assign mulSum   = {1'b0, hiAcc} + (loAcc[0] ? {1'b0, magB} : '0);
  assign divShift = {hiAcc, loAcc[WIDTH-1]};
  // Remainder stays below the divisor, so bit WIDTH of the difference is a clean borrow.
  assign divDiff  = divShift - {1'b0, magB};
  assign prod     = {hiAcc, loAcc};

  always_comb begin
    resHi = '0;
    resLo = '0;
    if (isDivQ) begin
      if (magB == '0) begin
        resHi = origA;
        resLo = '1;
      end else begin
        resHi = aNeg   ? -hiAcc : hiAcc;
        resLo = resNeg ? -loAcc : loAcc;
      end
    end else begin
      {resHi, resLo} = resNeg ? -prod : prod;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      conQ   <= '0;
      magB   <= '0;
      origA  <= '0;
      resNeg <= 1'b0;
      aNeg   <= 1'b0;
      hiAcc  <= '0;
      loAcc  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        state  <= RUN;
        cnt    <= '0;
        conQ   <= con;
        magB   <= magBIn;
        origA  <= opA;
        resNeg <= aNegIn ^ bNegIn;
        aNeg   <= aNegIn;
        hiAcc  <= '0;
        loAcc  <= magAIn;
        busy   <= 1'b1;
      end else begin
        case (state)
          RUN: begin
            if (isMulQ) begin
              hiAcc <= mulSum[WIDTH:1];
              loAcc <= {mulSum[0], loAcc[WIDTH-1:1]};
            end else if (!divDiff[WIDTH]) begin
              hiAcc <= divDiff[WIDTH-1:0];
              loAcc <= {loAcc[WIDTH-2:0], 1'b1};
            end else begin
              hiAcc <= divShift[WIDTH-1:0];
              loAcc <= {loAcc[WIDTH-2:0], 1'b0};
            end
            if (cnt == LAST) begin
              state <= FIX;
              done  <= 1'b1;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
          FIX: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: rtl/muldiv_hilo_unit.sv
// HI/LO register file with the iterative mul/div engine and EX-stage stall.
module muldiv_hilo_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  muldiv_hilo_unit_if.slave bus
);
  logic [WIDTH-1:0] hiReg, loReg, resHi, resLo;
  logic             busy, done;

  seq_muldiv_core #(.WIDTH(WIDTH)) core (
    .clk   (clk),
    .rst_n (rst_n),
    .start (bus.start),
    .con   (bus.con),
    .opA   (bus.op_a),
    .opB   (bus.op_b),
    .busy  (busy),
    .done  (done),
    .resHi (resHi),
    .resLo (resLo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hiReg <= '0;
      loReg <= '0;
    end else if (done) begin
      hiReg <= resHi;
      loReg <= resLo;
    end
  end

  // Reads always see committed HI/LO; in-flight results are never forwarded.
  assign bus.rd_data = bus.hilo_sel ? loReg : hiReg;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.stall   = busy & (bus.start | bus.hilo_rd);
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Randomized scoreboard bench for the HI/LO multiply/divide unit.
module tb_muldiv_hilo_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_hilo_unit_if #(.WIDTH(W)) bus();
  muldiv_hilo_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0, bad = 0, doneCnt = 0, pushed = 0;
  logic [63:0] sb[$];
  logic [31:0] lastLo = '0;

  function automatic logic [63:0] refModel(logic [3:0] c, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sa, sbv;
    logic signed [31:0] q, r;
    sa = $signed(a);
    sbv = $signed(b);
    case (c)
      4'b1100: return {32'd0, a} * {32'd0, b};
      4'b1110: return sa * sbv;
      4'b1101: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      4'b1111: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) return;
    end
    chk("waitIdleTimeout", 64'd1, 64'd0);
  endtask

  task automatic doOp(logic [3:0] c, logic [31:0] a, logic [31:0] b, bit push);
    waitIdle();
    bus.start = 1'b1;
    bus.con   = c;
    bus.op_a  = a;
    bus.op_b  = b;
    if (push) begin
      sb.push_back(refModel(c, a, b));
      lastLo = refModel(c, a, b) >> 0;
      pushed++;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("busyAfterAccept", 64'(bus.busy), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  c;
    logic [31:0] a, b;
    int stallCnt;
    bit sawDone;

    bus.start = 1'b0; bus.con = '0; bus.op_a = '0; bus.op_b = '0;
    bus.hilo_rd = 1'b0; bus.hilo_sel = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rstBusy", 64'(bus.busy), 64'd0);
    chk("rstStall", 64'(bus.stall), 64'd0);
    chk("rstDone", 64'(bus.done), 64'd0);
    chk("rstLo", 64'(bus.rd_data), 64'd0);
    bus.hilo_sel = 1'b0; #1;
    chk("rstHi", 64'(bus.rd_data), 64'd0);
    bus.hilo_sel = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    fork
      begin : monitor
        logic [63:0] e;
        logic [31:0] gotHi, gotLo;
        forever begin
          @(negedge clk);
          if (bus.done === 1'b1) begin
            doneCnt++;
            e = '0;
            if (sb.size() == 0) chk("unexpectedDone", 64'd1, 64'd0);
            else e = sb.pop_front();
            @(posedge clk);
            #1;
            bus.hilo_sel = 1'b0; #1;
            gotHi = bus.rd_data;
            bus.hilo_sel = 1'b1; #1;
            gotLo = bus.rd_data;
            chk("resultHi", 64'(gotHi), 64'(e[63:32]));
            chk("resultLo", 64'(gotLo), 64'(e[31:0]));
          end
        end
      end
    join_none

    // unsigned multiply with latency probe
    doOp(4'b1100, 32'hFFFF_FFFF, 32'd2, 1);
    repeat (31) @(posedge clk);
    #1 chk("doneEarly", 64'(bus.done), 64'd0);
    @(posedge clk);
    #1 chk("doneAtFix", 64'(bus.done), 64'd1);
    chk("busyAtFix", 64'(bus.busy), 64'd1);
    @(posedge clk);
    #4 chk("busyAfterE33", 64'(bus.busy), 64'd0);
    chk("doneAfterE33", 64'(bus.done), 64'd0);
    waitIdle();
    chk("donePulseOnce", 64'(doneCnt), 64'd1);

    doOp(4'b1110, -32'sd3, 32'd7, 1);
    doOp(4'b1111, -32'sd7, 32'd2, 1);
    doOp(4'b1101, 32'h1234, 32'd0, 1);
    doOp(4'b1111, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    doOp(4'b1111, 32'hFFFF_FF00, 32'd0, 1);
    doOp(4'b1101, 32'd100, 32'd7, 1);

    // non-muldiv con values are ignored
    waitIdle();
    bus.start = 1'b1; bus.con = 4'b1010;
    @(posedge clk);
    #1 chk("ignoredCon1010", 64'(bus.busy), 64'd0);
    bus.con = 4'b0111;
    @(posedge clk);
    #1 chk("ignoredCon0111", 64'(bus.busy), 64'd0);
    bus.start = 1'b0;

    // hazard and back-to-back accept
    waitIdle();
    bus.start = 1'b1; bus.con = 4'b1110; bus.op_a = 32'hFFFF_0001; bus.op_b = 32'h0000_7FFF;
    bus.hilo_rd = 1'b1;
    #1;
    chk("idleStartNoStall", 64'(bus.stall), 64'd0);
    chk("idleReadOld", 64'(bus.rd_data), 64'(lastLo));
    sb.push_back(refModel(4'b1110, 32'hFFFF_0001, 32'h0000_7FFF));
    pushed++;
    @(posedge clk);
    #1;
    bus.hilo_rd = 1'b0;
    bus.con = 4'b1101; bus.op_a = 32'hDEAD_BEEF; bus.op_b = 32'd1000;
    sb.push_back(refModel(4'b1101, 32'hDEAD_BEEF, 32'd1000));
    pushed++;
    @(posedge clk);
    #1 bus.hilo_rd = 1'b1;
    stallCnt = 0;
    sawDone = 0;
    for (int i = 0; i < 40 && !sawDone; i++) begin
      @(negedge clk);
      if (bus.stall === 1'b1) stallCnt++;
      if (bus.done === 1'b1) sawDone = 1;
    end
    chk("hazardSawDone", 64'(sawDone), 64'd1);
    chk("hazardStallCycles", 64'(stallCnt), 64'd32);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.hilo_rd = 1'b0;
    chk("backToBackNoBubble", 64'(bus.busy), 64'd1);
    lastLo = 32'hDEAD_BEEF / 32'd1000;

    // reset during RUN cycle 10
    doOp(4'b1100, 32'h0F0F_0F0F, 32'h1234_5678, 0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midRstBusy", 64'(bus.busy), 64'd0);
    chk("midRstDone", 64'(bus.done), 64'd0);
    chk("midRstLo", 64'(bus.rd_data), 64'd0);
    bus.hilo_sel = 1'b0; #1;
    chk("midRstHi", 64'(bus.rd_data), 64'd0);
    bus.hilo_sel = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lastLo = '0;
    repeat (40) @(negedge clk);
    chk("noDoneAfterAbort", 64'(doneCnt), 64'(pushed));

    // randomized operations
    for (int n = 0; n < 24; n++) begin
      c = {2'b11, 2'($urandom_range(0, 3))};
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      doOp(c, a, b, 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    waitIdle();
    repeat (4) @(negedge clk);
    chk("scoreboardDrained", 64'(sb.size()), 64'd0);
    chk("doneCount", 64'(doneCnt), 64'(pushed));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
